// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;

  // An IFQ entry carries {instr, pc}.
  function automatic int unsigned entry_w(input int unsigned xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding fetched {instr, pc} pairs; flush empties it in one cycle.
module ifq_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_q, rd_q;
  logic [CW-1:0]               cnt_q;
  logic                        do_push, do_pop;

  // A pop frees a slot, so a push is accepted at full when paired with a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, credit-limited sequential fetch, redirect/flush, IFQ.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned    PC_STEP  = PC_STEP_DEF,
  localparam int unsigned   CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            run_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            deq_valid_o,
  input  logic            deq_ready_i,
  output logic [XLEN-1:0] deq_instr_o,
  output logic [XLEN-1:0] deq_pc_o,
  output logic [CW-1:0]   ifq_count_o
);

  localparam int unsigned EW = entry_w(XLEN);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q, req_pc_q;
  logic            inflight_q;
  logic            issue, enq, deq, has_credit, ifq_empty, ifq_full;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic [EW-1:0]   head;

  // Queued plus in-flight words must fit, so a response always has a free slot.
  assign credit_used = {1'b0, count} + (CW+1)'(inflight_q);
  assign has_credit  = credit_used < (CW+1)'(DEPTH);

  assign issue       = (state_q == ST_RUN) & run_i & ~redirect_valid_i & has_credit;
  assign enq         = inflight_q & ~redirect_valid_i;
  assign deq_valid_o = ~ifq_empty & ~redirect_valid_i;
  assign deq         = deq_valid_o & deq_ready_i;

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign deq_instr_o = head[EW-1:XLEN];
  assign deq_pc_o    = head[XLEN-1:0];
  assign ifq_count_o = count;

  // Fetch enable FSM; an in-flight response still lands after dropping to IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (run_i)  state_q <= ST_RUN;
        ST_RUN:  if (!run_i) state_q <= ST_IDLE;
        default:             state_q <= ST_IDLE;
      endcase
    end
  end

  // PC and the single outstanding request; redirect kills the in-flight fetch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (redirect_valid_i) begin
        pc_q <= redirect_pc_i;
      end else if (issue) begin
        pc_q     <= pc_q + XLEN'(PC_STEP);
        req_pc_q <= pc_q;
      end
    end
  end

  ifq_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_ifq (
    .clk     (clk),
    .resetn  (resetn),
    .flush_i (redirect_valid_i),
    .push_i  (enq),
    .wdata_i ({imem_rdata_i, req_pc_q}),
    .pop_i   (deq),
    .rdata_o (head),
    .count_o (count),
    .full_o  (ifq_full),
    .empty_o (ifq_empty)
  );

  // Credit accounting must make an unpaired enqueue at full impossible.
  assert property (@(posedge clk) disable iff (!resetn) !(enq && ifq_full && !deq));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus directed scenarios.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run_i = 1'b0, redirect_valid_i = 1'b0, deq_ready_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
  logic        imem_req_o, deq_valid_o;
  logic [31:0] imem_addr_o, deq_instr_o, deq_pc_o;
  logic [3:0]  ifq_count_o;

  int checks = 0, failures = 0;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = '0, m_req_pc = '0;
  bit          m_run = 0, m_pend = 0;
  bit          mem_pend = 0;
  logic [31:0] mem_addr = '0;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .run_i(run_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_instr_o(deq_instr_o), .deq_pc_o(deq_pc_o), .ifq_count_o(ifq_count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input bit r_run, input bit r_redir, input logic [31:0] r_pc,
                     input bit r_rdy, input bit r_rstn);
    bit   e_req, e_dv;
    ent_t e;
    @(negedge clk);
    run_i = r_run; redirect_valid_i = r_redir; redirect_pc_i = r_pc;
    deq_ready_i = r_rdy; resetn = r_rstn;
    imem_rdata_i = mem_pend ? (mem_addr ^ MAGIC) : $urandom;
    #1;
    if (r_rstn) begin
      e_req = m_run && r_run && !r_redir && (mq.size() + int'(m_pend) < DEPTH);
      e_dv  = (mq.size() != 0) && !r_redir;
      chk("m_req",   32'(imem_req_o),  32'(e_req));
      chk("m_addr",  imem_addr_o,      m_pc);
      chk("m_dv",    32'(deq_valid_o), 32'(e_dv));
      chk("m_count", 32'(ifq_count_o), 32'(mq.size()));
      if (e_dv) begin
        chk("m_instr", deq_instr_o, mq[0].instr);
        chk("m_pc",    deq_pc_o,    mq[0].pc);
      end
      if (r_redir) begin
        mq.delete();
        m_pc   = r_pc;
        m_pend = 0;
      end else begin
        if (e_dv && r_rdy) void'(mq.pop_front());
        if (m_pend) begin
          e.instr = m_req_pc ^ MAGIC;
          e.pc    = m_req_pc;
          mq.push_back(e);
        end
        m_pend = e_req;
        if (e_req) begin
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
      m_run = r_run;
    end else begin
      mq.delete();
      m_pc = '0; m_run = 0; m_pend = 0;
    end
    mem_pend = imem_req_o;
    mem_addr = imem_addr_o;
  endtask

  task automatic go(input bit r_run, input bit r_rdy);
    cyc(r_run, 1'b0, 32'h0, r_rdy, 1'b1);
  endtask

  task automatic rst_seq();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset values
    rst_seq();
    chk("rst_req",   32'(imem_req_o),  0);
    chk("rst_addr",  imem_addr_o,      0);
    chk("rst_dv",    32'(deq_valid_o), 0);
    chk("rst_count", 32'(ifq_count_o), 0);
    chk("rst_instr", deq_instr_o,      0);
    chk("rst_pc",    deq_pc_o,         0);

    // Sequential streaming with dispatcher always ready
    go(1, 1); chk("t1_c0_req", 32'(imem_req_o), 0);
    go(1, 1); chk("t1_c1_req", 32'(imem_req_o), 1); chk("t1_c1_addr", imem_addr_o, 32'h0);
    go(1, 1); chk("t1_c2_addr", imem_addr_o, 32'h4); chk("t1_c2_dv", 32'(deq_valid_o), 0);
    go(1, 1); chk("t1_c3_dv", 32'(deq_valid_o), 1); chk("t1_c3_pc", deq_pc_o, 32'h0);
              chk("t1_c3_instr", deq_instr_o, 32'hA5A5_0000);
    go(1, 1); chk("t1_c4_pc", deq_pc_o, 32'h4); chk("t1_c4_instr", deq_instr_o, 32'hA5A5_0004);
              chk("t1_c4_count", 32'(ifq_count_o), 1);
    for (int i = 0; i < 6; i++) go(1, 1);

    // Credit stall at full, then a single-slot release
    for (int i = 0; i < 14; i++) go(1, 0);
    chk("t2_full_count", 32'(ifq_count_o), 8); chk("t2_full_req", 32'(imem_req_o), 0);
    go(1, 1);
    go(1, 0); chk("t2_rel_count", 32'(ifq_count_o), 7); chk("t2_rel_req", 32'(imem_req_o), 1);
    go(1, 0); chk("t2_rel_req2", 32'(imem_req_o), 0);
    go(1, 0); chk("t2_refull", 32'(ifq_count_o), 8);

    // Redirect with 5 queued and 1 in flight
    rst_seq();
    for (int i = 0; i < 7; i++) go(1, 0);
    cyc(1, 1, 32'h100, 0, 1);
    chk("t3_pre_count", 32'(ifq_count_o), 5); chk("t3_dv", 32'(deq_valid_o), 0);
    chk("t3_req", 32'(imem_req_o), 0);
    go(1, 0); chk("t3_count", 32'(ifq_count_o), 0); chk("t3_addr", imem_addr_o, 32'h100);
              chk("t3_req2", 32'(imem_req_o), 1);
    go(1, 0); chk("t3_dv2", 32'(deq_valid_o), 0);
    go(1, 0); chk("t3_pc", deq_pc_o, 32'h100); chk("t3_instr", deq_instr_o, 32'hA5A5_0100);

    // Redirect while the head is being offered and accepted
    for (int i = 0; i < 6; i++) go(1, 1);
    cyc(1, 1, 32'h200, 1, 1); chk("t4_dv", 32'(deq_valid_o), 0);
    go(1, 1); chk("t4_count", 32'(ifq_count_o), 0); chk("t4_addr", imem_addr_o, 32'h200);
    go(1, 1); chk("t4_dv2", 32'(deq_valid_o), 0);
    go(1, 1); chk("t4_pc", deq_pc_o, 32'h200); chk("t4_instr", deq_instr_o, 32'hA5A5_0200);

    // run drops with a fetch in flight
    rst_seq();
    go(1, 0); go(1, 0);
    go(0, 0); chk("t5_req_off", 32'(imem_req_o), 0);
    go(0, 0); chk("t5_count", 32'(ifq_count_o), 1); chk("t5_req_idle", 32'(imem_req_o), 0);
    go(1, 0); chk("t5_req_wake", 32'(imem_req_o), 0);
    go(1, 0); chk("t5_resume_req", 32'(imem_req_o), 1); chk("t5_resume_addr", imem_addr_o, 32'h4);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) go(1, 0);
    chk("t6_pre_count", 32'(ifq_count_o), 4);
    cyc(1, 0, 0, 0, 0);
    go(1, 0); chk("t6_req", 32'(imem_req_o), 0); chk("t6_addr", imem_addr_o, 0);
              chk("t6_count", 32'(ifq_count_o), 0); chk("t6_dv", 32'(deq_valid_o), 0);
              chk("t6_instr", deq_instr_o, 0); chk("t6_pc", deq_pc_o, 0);
    go(1, 0); chk("t6_restart", 32'(imem_req_o), 1); chk("t6_restart_addr", imem_addr_o, 0);
    go(1, 0); chk("t6_no_stale", 32'(ifq_count_o), 0);
    go(1, 0); chk("t6_first_pc", deq_pc_o, 0); chk("t6_first_dv", 32'(deq_valid_o), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 199) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
